// File: rtl/pipeline_reg_chain.sv
// pipeline_reg_chain: chain of STAGES valid/ready register slices, each with a main and a
// skid register, so every ready is a flop output and nothing runs combinationally from end
// to end. Total capacity is 2*STAGES words. Adds a synchronous flush and an occupancy count.
//
// Optional feature: define PIPE_STALL_CNT_EN to add the 16-bit saturating stall_cnt output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every stored word (data registers keep their values)
//   in_valid   upstream word valid
//   in_ready   chain can accept a word (registered, forced low by flush and during reset)
//   in_data    upstream payload
//   out_valid  word available at the output (gated low by flush)
//   out_ready  downstream accepts the word
//   out_data   payload from the last slice's main register
//   occupancy  number of words held, 0..2*STAGES
//   stall_cnt  edges with out_valid && !out_ready, saturating (PIPE_STALL_CNT_EN only)

module pipeline_reg_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = $clog2(2 * STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // Slice state is encoded by {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } slice_state_e;

  logic [STAGES-1:0] main_vld_q, main_vld_d;
  logic [STAGES-1:0] skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_q [STAGES];
  logic [DATA_W-1:0] main_d [STAGES];
  logic [DATA_W-1:0] skid_q [STAGES];
  logic [DATA_W-1:0] skid_d [STAGES];

  logic [STAGES-1:0] up_valid, up_ready, up_fire;
  logic [STAGES-1:0] dn_ready, dn_fire;
  logic [DATA_W-1:0] up_data [STAGES];

  // Low in reset, high from the first edge after reset release: keeps in_ready low in reset.
  logic rdy_en_q;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             in_fire, out_fire;

  // Inter-slice links. Slice g's downstream ready is slice g+1's registered upstream ready.
  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_valid[g] = in_valid;
      assign up_data[g]  = in_data;
      assign up_ready[g] = rdy_en_q & ~skid_vld_q[g] & ~flush;
    end else begin : g_body
      assign up_valid[g] = main_vld_q[g-1];
      assign up_data[g]  = main_q[g-1];
      assign up_ready[g] = ~skid_vld_q[g];
    end

    if (g == STAGES - 1) begin : g_tail
      assign dn_ready[g] = out_ready & ~flush;
    end else begin : g_mid
      assign dn_ready[g] = ~skid_vld_q[g+1];
    end

    assign up_fire[g] = up_valid[g] & up_ready[g];
    assign dn_fire[g] = main_vld_q[g] & dn_ready[g];
  end

  assign in_fire  = up_fire[0];
  assign out_fire = dn_fire[STAGES-1];

  assign in_ready  = up_ready[0];
  assign out_valid = main_vld_q[STAGES-1] & ~flush;
  assign out_data  = main_q[STAGES-1];
  assign occupancy = occ_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;

    for (int i = 0; i < STAGES; i++) begin
      unique case (slice_state_e'({skid_vld_q[i], main_vld_q[i]}))
        StEmpty: begin
          if (up_fire[i]) begin
            main_vld_d[i] = 1'b1;
            main_d[i]     = up_data[i];
          end
        end
        StOne: begin
          if (up_fire[i] && dn_fire[i]) begin
            main_d[i] = up_data[i];
          end else if (up_fire[i]) begin
            skid_vld_d[i] = 1'b1;
            skid_d[i]     = up_data[i];
          end else if (dn_fire[i]) begin
            main_vld_d[i] = 1'b0;
          end
        end
        StFull: begin
          if (dn_fire[i]) begin
            main_d[i]     = skid_q[i];
            skid_vld_d[i] = 1'b0;
          end
        end
        default: begin
          // Skid valid without main valid is unreachable; recover to empty.
          main_vld_d[i] = 1'b0;
          skid_vld_d[i] = 1'b0;
        end
      endcase
    end

    // Flush discards every word; internal moves are suppressed so data registers hold.
    if (flush) begin
      main_vld_d = '0;
      skid_vld_d = '0;
      main_d     = main_q;
      skid_d     = skid_q;
    end
  end

  always_comb begin
    occ_d = occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
    if (flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= '0;
      skid_vld_q <= '0;
      rdy_en_q   <= 1'b0;
      occ_q      <= '0;
      for (int i = 0; i < STAGES; i++) begin
        main_q[i] <= '0;
        skid_q[i] <= '0;
      end
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_en_q   <= 1'b1;
      occ_q      <= occ_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_reg_chain.sv
module tb_pipeline_reg_chain;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = $clog2(2 * STAGES + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_reg_chain #(
    .DATA_W (DATA_W),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                     input int e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Global time bound in case a DUT event never arrives.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] sent_q[$];
    logic [31:0] next_word;
    logic        in_f, out_f;
    int          n_sent, n_recv, cyc, m_occ;

    // Columns: in_valid, in_data, out_ready, flush | in_ready, out_valid, out_data, occupancy
    // Single word, latency STAGES-1 edges after acceptance.
    add(0, 32'h0,        1, 0,  1, 0, 32'h0,        0);
    add(1, 32'hA5A5A5A5, 1, 0,  1, 0, 32'h0,        0);
    add(0, 32'h0,        1, 0,  1, 0, 32'h0,        1);
    add(0, 32'h0,        1, 0,  1, 1, 32'hA5A5A5A5, 1);
    add(0, 32'h0,        1, 0,  1, 0, 32'hA5A5A5A5, 0);
    // Fill under backpressure.
    add(1, 32'h1,        0, 0,  1, 0, 32'hA5A5A5A5, 0);
    add(1, 32'h2,        0, 0,  1, 0, 32'hA5A5A5A5, 1);
    add(1, 32'h3,        0, 0,  1, 1, 32'h1,        2);
    add(1, 32'h4,        0, 0,  1, 1, 32'h1,        3);
    add(1, 32'h5,        0, 0,  0, 1, 32'h1,        4);
    // Drain while streaming.
    add(1, 32'h5,        1, 0,  0, 1, 32'h1,        4);
    add(1, 32'h5,        1, 0,  0, 1, 32'h2,        3);
    add(1, 32'h5,        1, 0,  1, 1, 32'h3,        2);
    add(1, 32'h6,        1, 0,  1, 1, 32'h4,        2);
    add(0, 32'h0,        1, 0,  1, 1, 32'h5,        2);
    add(0, 32'h0,        1, 0,  1, 1, 32'h6,        1);
    add(0, 32'h0,        1, 0,  1, 0, 32'h6,        0);
    // Flush with three words held.
    add(1, 32'h7,        0, 0,  1, 0, 32'h6,        0);
    add(1, 32'h8,        0, 0,  1, 0, 32'h6,        1);
    add(1, 32'h9,        0, 0,  1, 1, 32'h7,        2);
    add(1, 32'hA,        1, 1,  0, 0, 32'h7,        3);
    add(1, 32'h12345678, 1, 0,  1, 0, 32'h7,        0);
    add(0, 32'h0,        1, 0,  1, 0, 32'h7,        1);
    add(0, 32'h0,        1, 0,  1, 1, 32'h12345678, 1);
    add(0, 32'h0,        1, 0,  1, 0, 32'h12345678, 0);

    // Reset state.
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.occupancy", 32'(occupancy), 32'd0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // Directed vectors.
    for (int i = 0; i < vq.size(); i++) begin
      in_valid  = vq[i].iv;
      in_data   = vq[i].id;
      out_ready = vq[i].ordy;
      flush     = vq[i].fl;
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("v%0d.out_data", i), out_data, vq[i].e_od);
      chk($sformatf("v%0d.occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
      step();
    end
    flush = 1'b0;

    // Random valid/ready toggling, 1000 words against a FIFO scoreboard.
    n_sent = 0; n_recv = 0; cyc = 0; m_occ = 0;
    next_word = $urandom;
    while (n_recv < 1000 && cyc < 20000) begin
      in_valid  = (n_sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? next_word : $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd.occupancy", 32'(occupancy), 32'(m_occ));
      in_f  = in_valid && in_ready;
      out_f = out_valid && out_ready;
      if (out_f) begin
        if (sent_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd.spurious: got word %0h expected no word", out_data);
        end else begin
          chk("rnd.data", out_data, sent_q.pop_front());
        end
        n_recv++;
      end
      if (in_f) begin
        sent_q.push_back(next_word);
        n_sent++;
        next_word = $urandom;
      end
      m_occ = m_occ + int'(in_f) - int'(out_f);
      step();
      cyc++;
    end
    chk("rnd.words_received", 32'(n_recv), 32'd1000);
    chk("rnd.leftover", 32'(sent_q.size()), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;

`ifdef PIPE_STALL_CNT_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall.after_flush0", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    step();
    in_valid = 1'b0;
    step();
    chk("stall.start", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("stall.seven", 32'(stall_cnt), 32'd7);
    chk("stall.hold_data", out_data, 32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall.flush", 32'(stall_cnt), 32'd0);
    out_ready = 1'b1;
`endif

    // Reset mid-operation discards stored words at once.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE0001;
    step();
    in_data = 32'hCAFE0002;
    step();
    in_data = 32'hCAFE0003;
    step();
    chk("midop.out_valid_before", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midop.in_ready", 32'(in_ready), 32'd0);
    chk("midop.out_valid", 32'(out_valid), 32'd0);
    chk("midop.occupancy", 32'(occupancy), 32'd0);
    chk("midop.out_data", out_data, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    #1;
    chk("post.in_ready", 32'(in_ready), 32'd1);
    chk("post.out_valid", 32'(out_valid), 32'd0);
    chk("post.occupancy", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
